ycbcr422_to_rgb888: RTL and testbench

Converts the 16-bit YCbCr 4:2:2 word stream from the OV5640 capture/decode stage into 24-bit RGB888 pixels. It uses BT.601 full-range integer coefficients and a 3-stage pipeline. Sync and enable signals are delayed to stay aligned with the pixels. It sits directly downstream of the sensor decode stage and feeds the DDR3 frame-write path.

---
 rtl/ycbcr422_to_rgb888.sv | 147 ++++++++++++++
 tb/tb_ycbcr422_to_rgb888.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr422_to_rgb888.sv
// YCbCr 4:2:2 word stream to RGB888 converter with BT.601 full-range coefficients.
// Three registered stages: chroma offset, coefficient sums, floor/clamp; sync and enable ride alongside.
module ycbcr422_to_rgb888 #(
  parameter bit          CB_FIRST    = 1'b1,
  parameter logic [7:0]  CHROMA_INIT = 8'd128
) (
  input  logic        cmos_pclk_i,
  input  logic        rst_n_i,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [15:0] ycbcr_i,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] rgb_o
);

  // Per-channel chroma coefficients, index 0 = R, 1 = G, 2 = B.
  localparam logic signed [19:0] CB_COEF [3] = '{20'sd0,   -20'sd88,  20'sd454};
  localparam logic signed [19:0] CR_COEF [3] = '{20'sd359, -20'sd183, 20'sd0};

  logic       ph_reg;
  logic [7:0] cb_h_reg;
  logic [7:0] cr_h_reg;

  logic       cur_is_cb;
  logic [7:0] cb_sel;
  logic [7:0] cr_sel;

  logic [7:0]        y_s1_reg;
  logic signed [8:0] cb_s1_reg;
  logic signed [8:0] cr_s1_reg;
  logic signed [8:0] cb_off_next;
  logic signed [8:0] cr_off_next;

  logic signed [19:0] y_term;
  logic signed [19:0] cb_ext;
  logic signed [19:0] cr_ext;
  logic signed [19:0] sum_next [3];
  logic signed [19:0] sum_reg  [3];
  logic [7:0]         pix_next [3];
  logic [7:0]         pix_reg  [3];

  logic [2:0] vs_pipe_reg;
  logic [2:0] hs_pipe_reg;
  logic [2:0] de_pipe_reg;

  // Outside a line both components fall back to the init value; inside,
  // the word's own chroma pairs with the held value of the other type.
  always_comb begin
    cur_is_cb = ph_reg ^ CB_FIRST;
    cb_sel    = CHROMA_INIT;
    cr_sel    = CHROMA_INIT;
    if (hs_i) begin
      if (cur_is_cb) begin
        cb_sel = ycbcr_i[7:0];
        cr_sel = cr_h_reg;
      end else begin
        cb_sel = cb_h_reg;
        cr_sel = ycbcr_i[7:0];
      end
    end
    cb_off_next = {1'b0, cb_sel} - 9'd128;
    cr_off_next = {1'b0, cr_sel} - 9'd128;
  end

  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ph_reg   <= 1'b0;
      cb_h_reg <= CHROMA_INIT;
      cr_h_reg <= CHROMA_INIT;
    end else if (!hs_i) begin
      ph_reg   <= 1'b0;
      cb_h_reg <= CHROMA_INIT;
      cr_h_reg <= CHROMA_INIT;
    end else if (de_i) begin
      ph_reg <= ~ph_reg;
      if (cur_is_cb) cb_h_reg <= ycbcr_i[7:0];
      else           cr_h_reg <= ycbcr_i[7:0];
    end
  end

  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      y_s1_reg  <= 8'd0;
      cb_s1_reg <= 9'sd0;
      cr_s1_reg <= 9'sd0;
    end else begin
      y_s1_reg  <= ycbcr_i[15:8];
      cb_s1_reg <= cb_off_next;
      cr_s1_reg <= cr_off_next;
    end
  end

  always_comb begin
    y_term = {4'b0000, y_s1_reg, 8'h00};
    cb_ext = {{11{cb_s1_reg[8]}}, cb_s1_reg};
    cr_ext = {{11{cr_s1_reg[8]}}, cr_s1_reg};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      always_comb begin
        sum_next[gi] = y_term + cb_ext * CB_COEF[gi] + cr_ext * CR_COEF[gi];
      end

      // Bits [19:8] are the floored quotient; anything above bit 15 means >255.
      always_comb begin
        pix_next[gi] = sum_reg[gi][15:8];
        if (sum_reg[gi][19])
          pix_next[gi] = 8'h00;
        else if (|sum_reg[gi][18:16])
          pix_next[gi] = 8'hFF;
      end

      always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          sum_reg[gi] <= 20'sd0;
          pix_reg[gi] <= 8'h00;
        end else begin
          sum_reg[gi] <= sum_next[gi];
          pix_reg[gi] <= pix_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vs_pipe_reg <= 3'b000;
      hs_pipe_reg <= 3'b000;
      de_pipe_reg <= 3'b000;
    end else begin
      vs_pipe_reg <= {vs_pipe_reg[1:0], vs_i};
      hs_pipe_reg <= {hs_pipe_reg[1:0], hs_i};
      de_pipe_reg <= {de_pipe_reg[1:0], de_i};
    end
  end

  assign vs_o  = vs_pipe_reg[2];
  assign hs_o  = hs_pipe_reg[2];
  assign de_o  = de_pipe_reg[2];
  assign rgb_o = {pix_reg[0], pix_reg[1], pix_reg[2]};

endmodule

// File: tb/tb_ycbcr422_to_rgb888.sv
// Randomised and directed bench for ycbcr422_to_rgb888 against an arithmetic reference model.
// The model pairs chroma per the 4:2:2 phase rules and applies the BT.601 integer formulas directly.
module tb_ycbcr422_to_rgb888;

  localparam bit         CB_FIRST    = 1'b1;
  localparam logic [7:0] CHROMA_INIT = 8'd128;

  logic        cmos_pclk_i = 1'b0;
  logic        rst_n_i;
  logic        vs_i, hs_i, de_i;
  logic [15:0] ycbcr_i;
  logic        vs_o, hs_o, de_o;
  logic [23:0] rgb_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   m_ph, m_cb, m_cr;

  ycbcr422_to_rgb888 #(.CB_FIRST(CB_FIRST), .CHROMA_INIT(CHROMA_INIT)) dut (
    .cmos_pclk_i(cmos_pclk_i),
    .rst_n_i    (rst_n_i),
    .vs_i       (vs_i),
    .hs_i       (hs_i),
    .de_i       (de_i),
    .ycbcr_i    (ycbcr_i),
    .vs_o       (vs_o),
    .hs_o       (hs_o),
    .de_o       (de_o),
    .rgb_o      (rgb_o)
  );

  always #5 cmos_pclk_i = ~cmos_pclk_i;

  function automatic logic [7:0] clamp8(input int s);
    int f;
    f = s >>> 8;
    if (f < 0)   return 8'h00;
    if (f > 255) return 8'hFF;
    return 8'(f);
  endfunction

  function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
    int r, g, b;
    r = 256 * y + 359 * (cr - 128);
    g = 256 * y - 88 * (cb - 128) - 183 * (cr - 128);
    b = 256 * y + 454 * (cb - 128);
    return {clamp8(r), clamp8(g), clamp8(b)};
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '0;
    m_ph = 0;
    m_cb = CHROMA_INIT;
    m_cr = CHROMA_INIT;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // Drives one cycle of input and returns what the outputs must show after this edge.
  task automatic step(input logic vs, input logic hs, input logic de,
                      input logic [15:0] d, output exp_t e);
    exp_t n;
    int   y, cb, cr;
    bit   is_cb;
    vs_i = vs; hs_i = hs; de_i = de; ycbcr_i = d;
    y     = d[15:8];
    is_cb = ((m_ph == 0) == CB_FIRST);
    if (!hs) begin
      cb = CHROMA_INIT; cr = CHROMA_INIT;
    end else if (is_cb) begin
      cb = d[7:0]; cr = m_cr;
    end else begin
      cb = m_cb; cr = d[7:0];
    end
    n.vs = vs; n.hs = hs; n.de = de; n.rgb = ref_rgb(y, cb, cr);
    exp_q.push_back(n);
    @(posedge cmos_pclk_i);
    if (!hs) begin
      m_ph = 0; m_cb = CHROMA_INIT; m_cr = CHROMA_INIT;
    end else if (de) begin
      if (is_cb) m_cb = d[7:0];
      else       m_cr = d[7:0];
      m_ph = 1 - m_ph;
    end
    #1;
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b1; ycbcr_i = 16'hFF00;
    for (int i = 0; i < 4; i++) begin
      @(posedge cmos_pclk_i); #1;
      total++;
      if ({vs_o, hs_o, de_o} !== 3'b000 || rgb_o !== 24'h0) begin
        bad++;
        $display("FAIL reset_state: got ctrl=%b rgb=%h want ctrl=000 rgb=000000",
                 {vs_o, hs_o, de_o}, rgb_o);
      end
    end
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_grey();
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (i >= 2 && i < 20), (i >= 2 && i < 20), 16'h8080, e);
      total++;
      if ({vs_o, hs_o, de_o} !== {e.vs, e.hs, e.de} || (e.de && rgb_o !== e.rgb)) begin
        bad++;
        $display("FAIL grey_step%0d: got ctrl=%b rgb=%h want ctrl=%b rgb=%h",
                 i, {vs_o, hs_o, de_o}, rgb_o, {e.vs, e.hs, e.de}, e.rgb);
      end
      if (e.de) begin
        total++;
        if (rgb_o !== 24'h808080) begin
          bad++;
          $display("FAIL grey_value%0d: got %h want 808080", i, rgb_o);
        end
      end
    end
  endtask

  // Runs a short line of words with hs framing and returns the pixels shown while de_o is high.
  task automatic run_line(input string name, input logic [15:0] words[$], input int gap_after,
                          inout logic [23:0] got[$]);
    exp_t e;
    for (int i = 0; i < words.size() + gap_after; i++) begin
      if (i < words.size()) step(1'b1, 1'b1, 1'b1, words[i], e);
      else                  step(1'b1, 1'b0, 1'b0, 16'h0000, e);
      total++;
      if ({vs_o, hs_o, de_o} !== {e.vs, e.hs, e.de} || (e.de && rgb_o !== e.rgb)) begin
        bad++;
        $display("FAIL %s_step%0d: got ctrl=%b rgb=%h want ctrl=%b rgb=%h",
                 name, i, {vs_o, hs_o, de_o}, rgb_o, {e.vs, e.hs, e.de}, e.rgb);
      end
      if (e.de) got.push_back(rgb_o);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] w[$];
    logic [23:0] got[$];
    w = '{16'hFF80, 16'hFFFF};
    run_line("sat", w, 4, got);
    total++;
    if (got.size() != 2 || got[0] !== 24'hFFFFFF || got[1] !== 24'hFFA4FF) begin
      bad++;
      $display("FAIL saturation: got n=%0d p0=%h p1=%h want n=2 p0=FFFFFF p1=FFA4FF",
               got.size(), got.size() > 0 ? got[0] : 24'hx, got.size() > 1 ? got[1] : 24'hx);
    end
  endtask

  task automatic test_neg_clamp();
    logic [15:0] w[$];
    logic [23:0] got[$];
    w = '{16'h4C55, 16'h4CFF};
    run_line("neg", w, 4, got);
    total++;
    if (got.size() != 2 || got[0] !== 24'h4C5A00 || got[1] !== 24'hFE0000) begin
      bad++;
      $display("FAIL neg_clamp: got n=%0d p0=%h p1=%h want n=2 p0=4C5A00 p1=FE0000",
               got.size(), got.size() > 0 ? got[0] : 24'hx, got.size() > 1 ? got[1] : 24'hx);
    end
  endtask

  task automatic test_line_restart();
    logic [15:0] w[$];
    logic [23:0] got[$];
    w = '{16'h4010, 16'h4000, 16'h4020};
    run_line("restart_a", w, 4, got);
    w = '{16'h80FF, 16'h8080};
    run_line("restart_b", w, 4, got);
    total++;
    if (got.size() != 5 || got[3] !== 24'h8054FF) begin
      bad++;
      $display("FAIL line_restart: got n=%0d p0=%h want n=5 p0=8054FF",
               got.size(), got.size() > 3 ? got[3] : 24'hx);
    end
  endtask

  task automatic test_sparse();
    exp_t        e;
    logic [15:0] w[$];
    logic [23:0] dense[$];
    logic [23:0] sparse[$];
    for (int i = 0; i < 12; i++) w.push_back(16'($urandom));
    run_line("dense", w, 4, dense);
    for (int i = 0; i < 2 * w.size() + 4; i++) begin
      if (i < 2 * w.size()) step(1'b0, 1'b1, (i % 2 == 0), w[i / 2], e);
      else                  step(1'b0, 1'b0, 1'b0, 16'h0000, e);
      total++;
      if ({vs_o, hs_o, de_o} !== {e.vs, e.hs, e.de} || (e.de && rgb_o !== e.rgb)) begin
        bad++;
        $display("FAIL sparse_step%0d: got ctrl=%b rgb=%h want ctrl=%b rgb=%h",
                 i, {vs_o, hs_o, de_o}, rgb_o, {e.vs, e.hs, e.de}, e.rgb);
      end
      if (e.de) sparse.push_back(rgb_o);
    end
    total++;
    if (sparse.size() != dense.size() || sparse != dense) begin
      bad++;
      $display("FAIL sparse_vs_dense: got n=%0d want n=%0d, pixel streams differ",
               sparse.size(), dense.size());
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic hs;
    hs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) hs = ~hs;
      step(1'($urandom), hs, 1'($urandom), 16'($urandom), e);
      total++;
      if ({vs_o, hs_o, de_o} !== {e.vs, e.hs, e.de} || (e.de && rgb_o !== e.rgb)) begin
        bad++;
        $display("FAIL random_step%0d: got ctrl=%b rgb=%h want ctrl=%b rgb=%h",
                 i, {vs_o, hs_o, de_o}, rgb_o, {e.vs, e.hs, e.de}, e.rgb);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t        e;
    logic [15:0] w[$];
    logic [23:0] got[$];
    w = '{16'h4010, 16'h4000, 16'h4020};
    step(1'b0, 1'b0, 1'b0, 16'h0000, e);
    for (int i = 0; i < w.size(); i++) step(1'b1, 1'b1, 1'b1, w[i], e);
    #1 rst_n_i = 1'b0;
    #1;
    total++;
    if ({vs_o, hs_o, de_o} !== 3'b000 || rgb_o !== 24'h0) begin
      bad++;
      $display("FAIL async_reset_clear: got ctrl=%b rgb=%h want ctrl=000 rgb=000000",
               {vs_o, hs_o, de_o}, rgb_o);
    end
    #3 rst_n_i = 1'b1;
    model_reset();
    w = '{16'h80FF, 16'h8080};
    for (int i = 0; i < w.size() + 3; i++) begin
      if (i < w.size()) step(1'b0, 1'b1, 1'b1, w[i], e);
      else              step(1'b0, 1'b1, 1'b0, 16'h0000, e);
      total++;
      if ({vs_o, hs_o, de_o} !== {e.vs, e.hs, e.de} || (e.de && rgb_o !== e.rgb)) begin
        bad++;
        $display("FAIL async_step%0d: got ctrl=%b rgb=%h want ctrl=%b rgb=%h",
                 i, {vs_o, hs_o, de_o}, rgb_o, {e.vs, e.hs, e.de}, e.rgb);
      end
      if (e.de) got.push_back(rgb_o);
    end
    total++;
    if (got.size() != 2 || got[0] !== 24'h8054FF) begin
      bad++;
      $display("FAIL async_first_word: got n=%0d p0=%h want n=2 p0=8054FF",
               got.size(), got.size() > 0 ? got[0] : 24'hx);
    end
  endtask

  initial begin
    test_reset();
    test_grey();
    test_saturation();
    test_neg_clamp();
    test_line_restart();
    test_sparse();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
